// File: rtl/cpu_profiler.sv
// cpu_profiler: counts executed CPU cycles in total and per address-range
// channel, stopping when the CPU reaches FINAL_PC. Counters saturate and
// raise sticky overflow flags. Any counter is read back through a
// registered mux addressed by read_sel.
// Build option: define CPU_PROFILER_BCD_EN for packed-BCD counters
// (decimal display), otherwise the counters are plain binary.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | after reset, counters frozen, waiting for start
// RUN    | counting pc_valid cycles, FINAL_PC ends the run
// DONE   | run finished, counters frozen, finished=1 gates the CPU
module cpu_profiler #(
    parameter int PC_WIDTH     = 12,
    parameter int COUNT_WIDTH  = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int FINAL_PC     = 4095
) (
    input  logic                             CLK_50,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PC_WIDTH-1:0]              pc,
    input  logic                             pc_valid,
    input  logic [NUM_CHANNELS*PC_WIDTH-1:0] ch_lo,
    input  logic [NUM_CHANNELS*PC_WIDTH-1:0] ch_hi,
    input  logic [3:0]                       read_sel,
    output logic [COUNT_WIDTH-1:0]           read_count,
    output logic                             running,
    output logic                             finished,
    output logic [NUM_CHANNELS:0]            overflow
);

    localparam int NCNT = NUM_CHANNELS + 1;
    localparam int NDIG = COUNT_WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic [COUNT_WIDTH-1:0] cnt_t;

`ifdef CPU_PROFILER_BCD_EN
    // Saturation point is every digit at 9.
    function automatic logic cnt_at_max(input cnt_t v);
        logic m;
        m = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (v[d*4 +: 4] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

    // Decimal ripple-carry increment, digit 0 is least significant.
    function automatic cnt_t cnt_inc(input cnt_t v);
        cnt_t r;
        logic c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic cnt_at_max(input cnt_t v);
        return &v;
    endfunction

    function automatic cnt_t cnt_inc(input cnt_t v);
        return v + cnt_t'(1);
    endfunction
`endif

    state_t                        state_q, state_d;
    logic [NCNT-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NCNT-1:0]               ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0]        rd_q, rd_d;
    logic [NCNT-1:0]               hit;

    // Range match per counter; slot 0 is the total and always hits.
    // An inverted range (lo > hi) can never satisfy both compares.
    always_comb begin
        hit    = '0;
        hit[0] = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            hit[i+1] = (pc >= ch_lo[i*PC_WIDTH +: PC_WIDTH]) &&
                       (pc <= ch_hi[i*PC_WIDTH +: PC_WIDTH]);
        end
    end

    // Next state and counter updates; start wins over everything but reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
            ovf_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_RUN: begin
                    if (pc_valid) begin
                        for (int i = 0; i < NCNT; i++) begin
                            if (hit[i]) begin
                                if (cnt_at_max(cnt_q[i])) ovf_d[i] = 1'b1;
                                else                      cnt_d[i] = cnt_inc(cnt_q[i]);
                            end
                        end
                        if (pc == PC_WIDTH'(FINAL_PC)) state_d = S_DONE;
                    end
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read-back mux; selects beyond the last channel return zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NCNT; i++) begin
            if ({1'b0, read_sel} == 5'(i)) rd_d = cnt_q[i];
        end
    end

    // State, counters, flags and read register.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovf_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
        end
    end

    assign read_count = rd_q;
    assign running    = (state_q == S_RUN);
    assign finished   = (state_q == S_DONE);
    assign overflow   = ovf_q;

endmodule
